// File: rtl/fakeram7_adapter_pkg.sv
// Shared types and sizing helpers for the fakeram7 port adapter and its response FIFO.
// Read by fakeram7_port_adapter.sv, whose write-ack option is FAKERAM7_ADAPTER_WACK_EN.
package fakeram7_adapter_pkg;

    // Widest data path a response entry can carry; the adapter's BITS must not exceed it.
    localparam int RESP_DATA_W = 32;

    typedef struct packed {
        logic [RESP_DATA_W-1:0] rdata;
        logic                   is_wr;
    } resp_entry_t;

    // Bits needed to count 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fakeram7_adapter_resp_fifo.sv
// Circular response FIFO: holds captured macro read data (and write acks) until the
// consumer takes them. Head entry is presented combinationally.
module fakeram7_adapter_resp_fifo
    import fakeram7_adapter_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  resp_entry_t                  push_entry,
    input  logic                         pop,
    output resp_entry_t                  head_entry,
    output logic                         valid,
    output logic [occ_width(DEPTH)-1:0]  count
);

    localparam int CW = occ_width(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    resp_entry_t   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_entry;
        end
    end

    assign valid      = (count != '0);
    assign full       = (count == CW'(DEPTH));
    assign head_entry = mem[head];

    assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && full));
    assert property (@(posedge clk) disable iff (!rst_n) !(pop && !valid));

endmodule

// File: rtl/fakeram7_port_adapter.sv
// Valid/ready front-end for one port of a fakeram7 dual-port macro: drives the macro
// pins and buffers read data. Define FAKERAM7_ADAPTER_WACK_EN to also acknowledge writes.
module fakeram7_port_adapter
    import fakeram7_adapter_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int RESP_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS-1:0]       req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [BITS-1:0]       resp_rdata,
`ifdef FAKERAM7_ADAPTER_WACK_EN
    output logic                  resp_is_wr,
`endif
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd
);

    localparam int CW = occ_width(RESP_DEPTH);

    logic          running;
    logic          accept;
    logic          credit_ok;
    logic          inflight;
    logic          inflight_wr;
    logic          pop;
    logic          fifo_valid;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occ;
    resp_entry_t   push_entry;
    resp_entry_t   head_entry;

    // Holds req_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // A same-cycle pop is not credited, keeping resp_ready off the req_ready path.
    assign occ       = fifo_count + CW'(inflight);
    assign credit_ok = (occ < CW'(RESP_DEPTH));

`ifdef FAKERAM7_ADAPTER_WACK_EN
    assign req_ready = running & credit_ok;
`else
    assign req_ready = running & (req_we | credit_ok);
`endif

    assign accept = req_valid & req_ready;

    // Pins are forced to zero whenever the macro is not enabled.
    assign sram_ce    = accept;
    assign sram_we    = accept & req_we;
    assign sram_addr  = accept ? req_addr  : '0;
    assign sram_wd    = accept ? req_wdata : '0;
    assign sram_wmask = accept ? req_wmask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight    <= 1'b0;
            inflight_wr <= 1'b0;
        end else begin
`ifdef FAKERAM7_ADAPTER_WACK_EN
            inflight    <= accept;
            inflight_wr <= accept & req_we;
`else
            inflight    <= accept & ~req_we;
            inflight_wr <= 1'b0;
`endif
        end
    end

    always_comb begin
        push_entry       = '0;
        push_entry.rdata = RESP_DATA_W'(sram_rd);
        push_entry.is_wr = inflight_wr;
    end

    fakeram7_adapter_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .valid      (fifo_valid),
        .count      (fifo_count)
    );

    assign pop        = fifo_valid & resp_ready;
    assign resp_valid = fifo_valid;
    // Write acks store whatever rd_out showed; their data is zeroed on the way out.
    assign resp_rdata = head_entry.is_wr ? '0 : BITS'(head_entry.rdata);

`ifdef FAKERAM7_ADAPTER_WACK_EN
    assign resp_is_wr = head_entry.is_wr;
`endif

endmodule

// File: tb/tb_fakeram7_port_adapter.sv
// Directed bench for fakeram7_port_adapter with a behavioural fakeram7 port model.
module tb_fakeram7_port_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        sram_ce;
    logic        sram_we;
    logic [8:0]  sram_addr;
    logic [31:0] sram_wd;
    logic [31:0] sram_wmask;
    logic [31:0] sram_rd;
    logic        preload;

`ifdef FAKERAM7_ADAPTER_WACK_EN
    logic        resp_is_wr;
    localparam bit WACK = 1'b1;
`else
    localparam bit WACK = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fakeram7_port_adapter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
`ifdef FAKERAM7_ADAPTER_WACK_EN
        .resp_is_wr (resp_is_wr),
`endif
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wd    (sram_wd),
        .sram_wmask (sram_wmask),
        .sram_rd    (sram_rd)
    );

    function automatic logic [31:0] init_val(input int a);
        logic [31:0] v;
        v = (a == 'h1A5) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(a));
        return v;
    endfunction

    // Macro port model: masked write, read data registered at the enabling edge.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
        end else if (sram_ce) begin
            if (sram_we)
                mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
            else
                sram_rd <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx;
        int got;
        bit acc;

        vecs[0] = '{1'b1, 9'h1A5, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h0};
        vecs[1] = '{1'b0, 9'h1A5, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_5678};
        vecs[2] = '{1'b0, 9'h010, 32'h0,         32'h0,         32'hC0DE_0010};
        vecs[3] = '{1'b1, 9'h010, 32'hA5A5_A5A5, 32'h0000_FFFF, 32'h0};
        vecs[4] = '{1'b0, 9'h010, 32'h0,         32'hFFFF_FFFF, 32'hC0DE_A5A5};
        vecs[5] = '{1'b1, 9'h1FF, 32'hCAFE_F00D, 32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{1'b0, 9'h1FF, 32'h0,         32'h0,         32'hCAFE_F00D};
        vecs[7] = '{1'b0, 9'h000, 32'h0,         32'h0,         32'hC0DE_0000};

        // Reset with a request already presented.
        rst_n = 1'b0; preload = 1'b1; resp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h005;
        req_wdata = 32'h0; req_wmask = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_sram_ce", sram_ce, 0);
        check("rst_resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        preload = 1'b0; rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check("rel_ready_same_cycle", req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rel_ready_next_cycle", req_ready, 1);
        @(posedge clk); #1;

        // Table-driven single transactions.
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_we = vecs[i].we; req_addr = vecs[i].addr;
            req_wdata = vecs[i].wdata; req_wmask = vecs[i].wmask;
            @(negedge clk);
            check($sformatf("v%0d_ready", i), req_ready, 1);
            check($sformatf("v%0d_ce", i), sram_ce, 1);
            check($sformatf("v%0d_we", i), sram_we, vecs[i].we);
            check($sformatf("v%0d_addr", i), sram_addr, vecs[i].addr);
            check($sformatf("v%0d_wd", i), sram_wd, vecs[i].wdata);
            check($sformatf("v%0d_wmask", i), sram_wmask, vecs[i].wmask);
            @(posedge clk); #1;
            req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
            if (!vecs[i].we || WACK) begin
                @(negedge clk);
                check($sformatf("v%0d_resp_early", i), resp_valid, 0);
                check($sformatf("v%0d_idle_ce", i), sram_ce, 0);
                check($sformatf("v%0d_idle_addr", i), sram_addr, 0);
                @(posedge clk); #1;
                @(negedge clk);
                check($sformatf("v%0d_resp_valid", i), resp_valid, 1);
                check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
`ifdef FAKERAM7_ADAPTER_WACK_EN
                check($sformatf("v%0d_is_wr", i), resp_is_wr, vecs[i].we);
`endif
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("table_drained", resp_valid, 0);
        @(posedge clk); #1;

        // Back-to-back reads 0..7 under full response readiness.
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 9'(c);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 8) check($sformatf("b2b_ready_c%0d", c), req_ready, 1);
            check($sformatf("b2b_valid_c%0d", c), resp_valid, (c >= 2 && c <= 9));
            if (c >= 2 && c <= 9)
                check($sformatf("b2b_rdata_c%0d", c), resp_rdata, init_val(c - 2));
            @(posedge clk); #1;
        end

        // Backpressure: five reads against a stalled consumer.
        resp_ready = 1'b0; idx = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h020;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (resp_valid) check($sformatf("bp_stable_c%0d", c), resp_rdata, init_val('h20));
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                req_addr = 9'('h20 + idx);
            end
        end
        check("bp_accepted", 32'(idx), 3);
        @(negedge clk);
        check("bp_full_ready", req_ready, 0);
        check("bp_full_valid", resp_valid, 1);
        @(posedge clk); #1;
        resp_ready = 1'b1; got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (resp_valid) begin
                check($sformatf("bp_order_%0d", got), resp_rdata, init_val('h20 + got));
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx == 5) req_valid = 1'b0;
                else req_addr = 9'('h20 + idx);
            end
        end
        check("bp_all_accepted", 32'(idx), 5);
        check("bp_all_responses", 32'(got), 5);

        // Reset during the cycle after a read accept drops that read.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h030;
        @(negedge clk);
        check("mid_rst_accept", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ce", sram_ce, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_valid", resp_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("mid_rst_no_resp_c%0d", c), resp_valid, 0);
        end
        @(posedge clk); #1;

`ifdef FAKERAM7_ADAPTER_WACK_EN
        // Write, read, write: acks interleave in order with read data.
        begin
            logic        ex_wr [3];
            logic [31:0] ex_rd [3];
            logic [8:0]  ad [3];
            ex_wr = '{1'b1, 1'b0, 1'b1};
            ex_rd = '{32'h0, init_val('h41), 32'h0};
            ad    = '{9'h040, 9'h041, 9'h042};
            idx = 0; got = 0;
            req_valid = 1'b1; req_we = 1'b1; req_addr = ad[0];
            req_wdata = 32'h0000_0001; req_wmask = 32'hFFFF_FFFF;
            for (int c = 0; c < 20 && got < 3; c++) begin
                @(negedge clk);
                acc = req_valid && req_ready;
                if (resp_valid) begin
                    check($sformatf("wack_is_wr_%0d", got), resp_is_wr, ex_wr[got]);
                    check($sformatf("wack_rdata_%0d", got), resp_rdata, ex_rd[got]);
                    got++;
                end
                @(posedge clk); #1;
                if (acc) begin
                    idx++;
                    if (idx == 3) req_valid = 1'b0;
                    else begin
                        req_addr = ad[idx];
                        req_we   = (idx != 1);
                    end
                end
            end
            check("wack_responses", 32'(got), 3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
